fir_sample_sched: RTL and testbench

//  Controller for the 10-tap transposed FIR MAC. It divides the 12 MHz clock into the sample strobe.
//  It buffers one input sample through a valid/ready handshake and presents it to the MAC.
//  It owns double-buffered coefficients and swaps them only on sample boundaries.
//  It captures the MAC result and drains the tap pipeline with zeros when the filter is disabled.

---
 rtl/fir_sample_sched.sv | 185 ++++++++++++++++++
 tb/tb_fir_sample_sched.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sched.sv
// Sample scheduler for the 10-tap transposed FIR MAC: divides the clock into the sample strobe,
// buffers one input sample, double-buffers coefficients and zero-flushes the taps on disable.
module fir_sample_sched #(
    parameter int SAMPLE_DIV = 40,
    parameter int NTAP       = 10,
    parameter int DW         = 16,
    parameter int CW         = 16
) (
    input  logic                 iClk_12M,
    input  logic                 iRst,
    input  logic                 iEnable,
    input  logic                 iInValid,
    input  logic signed [DW-1:0] iInData,
    output logic                 oInReady,
    input  logic                 iCoeffWr,
    input  logic [3:0]           iCoeffAddr,
    input  logic signed [CW-1:0] iCoeffData,
    input  logic                 iCoeffCommit,
    output logic                 oCommitDone,
    input  logic                 iClrStatus,
    output logic [NTAP*CW-1:0]   oCoeffBus,
    output logic                 oEnSample,
    output logic signed [DW-1:0] oFirIn,
    input  logic signed [DW-1:0] iMac,
    output logic signed [DW-1:0] oOut,
    output logic                 oOutValid,
    output logic                 oUnderflow,
    output logic                 oBusy
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int FC_W  = $clog2(NTAP + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                  buf_full_q, buf_full_d;
    logic signed [DW-1:0]  smp_buf_q, smp_buf_d;
    logic signed [DW-1:0]  fir_in_q, fir_in_d;
    logic signed [DW-1:0]  out_q, out_d;
    logic                  out_vld_q, out_vld_d;
    logic                  underflow_q, underflow_d;
    logic                  pending_q, pending_d;
    logic signed [CW-1:0]  shadow_q [NTAP];
    logic signed [CW-1:0]  shadow_d [NTAP];
    logic signed [CW-1:0]  active_q [NTAP];
    logic signed [CW-1:0]  active_d [NTAP];

    logic load, strobe, flush_enter, xfer, do_copy;

    // Load precedes the strobe by one cycle so oFirIn is settled for the whole strobe.
    assign load        = (state_q != S_IDLE) && (cnt_q == CNT_W'(SAMPLE_DIV - 2));
    assign strobe      = (state_q != S_IDLE) && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign flush_enter = (state_q == S_RUN) && (state_d == S_FLUSH);
    assign xfer        = iInValid && oInReady;

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (iEnable) state_d = S_RUN;
            S_RUN:   if (!iEnable) state_d = S_FLUSH;
            S_FLUSH: if (strobe && (flush_cnt_q == FC_W'(NTAP))) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy       = (state_q != S_IDLE);
        oEnSample   = strobe;
        oInReady    = (state_q == S_RUN) && !buf_full_q;
        do_copy     = pending_q && ((state_q == S_IDLE) || load);
        oCommitDone = do_copy;
    end

    always_comb begin
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (flush_enter) begin
            flush_cnt_d = '0;
        end else if ((state_q == S_FLUSH) && strobe) begin
            flush_cnt_d = flush_cnt_q + FC_W'(1);
        end

        buf_full_d  = buf_full_q;
        smp_buf_d   = smp_buf_q;
        fir_in_d    = fir_in_q;
        underflow_d = underflow_q;
        if (iClrStatus) begin
            underflow_d = 1'b0;
        end
        if (load && (state_q == S_RUN)) begin
            if (buf_full_q) begin
                fir_in_d   = smp_buf_q;
                buf_full_d = 1'b0;
            end else begin
                fir_in_d    = '0;
                underflow_d = 1'b1;
            end
        end else if (load) begin
            fir_in_d = '0;
        end
        // A sample taken on the load cycle waits for the next period; flush entry discards it.
        if (xfer) begin
            buf_full_d = 1'b1;
            smp_buf_d  = iInData;
        end
        if (flush_enter) begin
            buf_full_d = 1'b0;
        end

        out_vld_d = strobe;
        out_d     = strobe ? iMac : out_q;

        shadow_d = shadow_q;
        if (iCoeffWr && (int'(iCoeffAddr) < NTAP)) begin
            shadow_d[iCoeffAddr] = iCoeffData;
        end
        active_d  = do_copy ? shadow_q : active_q;
        pending_d = iCoeffCommit || (pending_q && !do_copy);
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            cnt_q       <= '0;
            flush_cnt_q <= '0;
            buf_full_q  <= 1'b0;
            smp_buf_q   <= '0;
            fir_in_q    <= '0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            underflow_q <= 1'b0;
            pending_q   <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            buf_full_q  <= buf_full_d;
            smp_buf_q   <= smp_buf_d;
            fir_in_q    <= fir_in_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            underflow_q <= underflow_d;
            pending_q   <= pending_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
        end
    end

    always_comb begin
        oCoeffBus = '0;
        for (int k = 0; k < NTAP; k++) begin
            oCoeffBus[k*CW +: CW] = active_q[k];
        end
    end

    assign oFirIn     = fir_in_q;
    assign oOut       = out_q;
    assign oOutValid  = out_vld_q;
    assign oUnderflow = underflow_q;

endmodule

// File: tb/tb_fir_sample_sched.sv
// Bench for fir_sample_sched: a direct-form MAC stand-in closes the loop, and a
// rule-level model of strobe timing, buffering, coefficients and outputs is compared every cycle.
module tb_fir_sample_sched;

    localparam int DIV = 40;
    localparam int NT  = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               in_vld;
    logic signed [15:0] in_data;
    logic               in_rdy;
    logic               coeff_wr;
    logic [3:0]         coeff_addr;
    logic signed [15:0] coeff_data;
    logic               commit;
    logic               commit_done;
    logic               clr;
    logic [NT*16-1:0]   coeff_bus;
    logic               en_smp;
    logic signed [15:0] fir_in;
    logic signed [15:0] mac;
    logic signed [15:0] out;
    logic               out_vld;
    logic               uf;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_sample_sched #(.SAMPLE_DIV(DIV), .NTAP(NT), .DW(16), .CW(16)) dut (
        .iClk_12M(clk), .iRst(rst), .iEnable(en), .iInValid(in_vld), .iInData(in_data),
        .oInReady(in_rdy), .iCoeffWr(coeff_wr), .iCoeffAddr(coeff_addr), .iCoeffData(coeff_data),
        .iCoeffCommit(commit), .oCommitDone(commit_done), .iClrStatus(clr), .oCoeffBus(coeff_bus),
        .oEnSample(en_smp), .oFirIn(fir_in), .iMac(mac), .oOut(out), .oOutValid(out_vld),
        .oUnderflow(uf), .oBusy(busy)
    );

    // Stand-in for the external MAC: direct-form sum over the current sample and 9 past ones.
    logic signed [15:0] hist [NT-1];
    always_comb begin : mac_stub
        longint acc;
        acc = 0;
        acc += longint'($signed(coeff_bus[15:0])) * longint'(fir_in);
        for (int k = 1; k < NT; k++) begin
            acc += longint'($signed(coeff_bus[k*16 +: 16])) * longint'(hist[k-1]);
        end
        mac = acc[15:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NT-1; k++) hist[k] <= '0;
        end else if (en_smp) begin
            hist[0] <= fir_in;
            for (int k = 1; k < NT-1; k++) hist[k] <= hist[k-1];
        end
    end

    // Reference model state
    int                 mst;        // 0 idle, 1 run, 2 flush
    int                 cyc;
    int                 run_start;
    bit                 m_full, m_outvld, m_uf, m_pend;
    int                 m_fl;
    logic signed [15:0] m_buf, m_firin, m_out;
    logic signed [15:0] m_sh  [NT];
    logic signed [15:0] m_act [NT];
    logic signed [15:0] m_x   [NT];

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mpos();
        return (mst == 0) ? 0 : (cyc - run_start) % DIV;
    endfunction

    function automatic logic [159:0] pack_act();
        logic [159:0] v;
        v = '0;
        for (int k = 0; k < NT; k++) v[k*16 +: 16] = m_act[k];
        return v;
    endfunction

    task automatic model_reset();
        mst = 0; m_full = 0; m_outvld = 0; m_uf = 0; m_pend = 0; m_fl = 0;
        m_buf = '0; m_firin = '0; m_out = '0;
        for (int k = 0; k < NT; k++) begin
            m_sh[k] = '0; m_act[k] = '0; m_x[k] = '0;
        end
    endtask

    task automatic check_outputs();
        int p;
        p = mpos();
        chk("busy",   busy,        mst != 0);
        chk("strobe", en_smp,      (mst != 0) && (p == DIV-1));
        chk("ready",  in_rdy,      (mst == 1) && !m_full);
        chk("firin",  fir_in,      m_firin);
        chk("out",    out,         m_out);
        chk("outvld", out_vld,     m_outvld);
        chk("uflow",  uf,          m_uf);
        chk("cdone",  commit_done, m_pend && ((mst == 0) || (p == DIV-2)));
        chk("coeffs", coeff_bus,   pack_act());
    endtask

    // Apply the rules for the current cycle's inputs, advance one clock, then compare.
    task automatic tick();
        int p, nst;
        bit strobe, load, xfer, copy;
        longint acc;
        p      = mpos();
        strobe = (mst != 0) && (p == DIV-1);
        load   = (mst != 0) && (p == DIV-2);
        xfer   = in_vld && (mst == 1) && !m_full;
        copy   = m_pend && ((mst == 0) || load);
        nst    = mst;
        if (mst == 0 && en) nst = 1;
        else if (mst == 1 && !en) nst = 2;
        else if (mst == 2 && strobe && m_fl == NT) nst = 0;

        if (strobe) begin
            for (int k = NT-1; k > 0; k--) m_x[k] = m_x[k-1];
            m_x[0] = m_firin;
            acc = 0;
            for (int k = 0; k < NT; k++) acc += longint'(m_act[k]) * longint'(m_x[k]);
            m_out = acc[15:0];
        end
        m_outvld = strobe;
        if (clr) m_uf = 0;
        if (load && mst == 1) begin
            if (m_full) begin
                m_firin = m_buf; m_full = 0;
            end else begin
                m_firin = '0; m_uf = 1;
            end
        end else if (load) begin
            m_firin = '0;
        end
        if (xfer) begin
            m_full = 1; m_buf = in_data;
        end
        if (mst == 1 && nst == 2) begin
            m_full = 0; m_fl = 0;
        end
        if (mst == 2 && strobe) m_fl++;
        if (copy) for (int k = 0; k < NT; k++) m_act[k] = m_sh[k];
        if (coeff_wr && coeff_addr < NT) m_sh[coeff_addr] = coeff_data;
        m_pend = commit || (m_pend && !copy);

        @(posedge clk);
        #1;
        cyc++;
        if (mst == 0 && nst == 1) run_start = cyc;
        mst = nst;
        check_outputs();
    endtask

    task automatic wr_coeff(input int addr, input int val);
        coeff_wr = 1; coeff_addr = 4'(addr); coeff_data = 16'(val);
        tick();
        coeff_wr = 0;
    endtask

    initial begin
        int s1, s2, n, found;
        rst = 1; en = 0; in_vld = 0; in_data = '0; coeff_wr = 0; coeff_addr = '0;
        coeff_data = '0; commit = 0; clr = 0; cyc = 0; run_start = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_outputs();

        // Coefficient load in IDLE
        for (int k = 0; k < NT; k++) wr_coeff(k, k + 1);
        commit = 1; tick(); commit = 0;
        chk("t2_done", commit_done, 1'b1);
        tick();
        chk("t2_tap0", coeff_bus[15:0], 16'd1);
        chk("t2_tap9", coeff_bus[159:144], 16'd10);
        wr_coeff(10, 55);
        coeff_wr = 1; coeff_addr = 4'd0; coeff_data = 16'sd7; commit = 1; tick(); commit = 0;
        coeff_addr = 4'd1; coeff_data = 16'sd99; tick(); coeff_wr = 0;
        tick();
        chk("t2_wrcommit", coeff_bus[15:0], 16'd7);
        chk("t2_wrcopy", coeff_bus[31:16], 16'd2);
        wr_coeff(0, 1); wr_coeff(1, 2);
        commit = 1; tick(); commit = 0; tick();
        wr_coeff(5, -300);

        // Free-running with no data: strobe period and underflow
        en = 1;
        s1 = -1; s2 = -1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (en_smp) begin
                if (s1 < 0) begin
                    s1 = cyc;
                    chk("t1_uf", uf, 1'b1);
                    chk("t1_firin", fir_in, 16'd0);
                end else if (s2 < 0) s2 = cyc;
            end
        end
        chk("t1_period", 32'(s2 - s1), 32'd40);

        // Commit while running lands on the load cycle
        for (int i = 0; i < 60 && mpos() != 5; i++) tick();
        commit = 1; tick(); commit = 0;
        for (int i = 0; i < 60 && mpos() != DIV-2; i++) tick();
        chk("t3_old", coeff_bus[95:80], 16'd6);
        chk("t3_done", commit_done, 1'b1);
        tick();
        chk("t3_new", coeff_bus[95:80], 16'hFED4);
        chk("t3_strobe", en_smp, 1'b1);
        wr_coeff(5, 6);
        commit = 1; tick(); commit = 0;

        // Sample offered one cycle after the load cycle
        for (int i = 0; i < 60 && mpos() != DIV-1; i++) tick();
        in_vld = 1; in_data = 16'sh0100; tick(); in_vld = 0;
        chk("t4_notready", in_rdy, 1'b0);
        for (int i = 0; i < 60 && mpos() != DIV-1; i++) tick();
        chk("t4_firin", fir_in, 16'h0100);
        clr = 1; tick(); clr = 0;
        chk("uf_clr", uf, 1'b0);

        // Impulse followed by disable: 11 flush strobes
        repeat (450) tick();
        for (int i = 0; i < 60 && mpos() != 0; i++) tick();
        in_vld = 1; in_data = 16'sd1; tick(); in_vld = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (en_smp) found = 1;
        end
        chk("t5_strobe_seen", found, 1);
        chk("t5_imp_in", fir_in, 16'd1);
        en = 0; tick();
        chk("t5_imp_out", out, 16'd1);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (out_vld) begin
                chk("t5_flush_out", out, (n < 9) ? 16'(n + 2) : 16'd0);
                n++;
            end
            if (!busy) break;
        end
        chk("t5_pulses", n, 11);
        chk("t5_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a period
        en = 1; tick();
        for (int i = 0; i < 60 && mpos() != 20; i++) tick();
        #2;
        rst = 1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 0; en = 0;
        repeat (100) tick();

        // Randomized traffic
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            in_vld     = ($urandom % 25) == 0;
            in_data    = 16'($urandom);
            clr        = ($urandom % 200) == 0;
            coeff_wr   = ($urandom % 20) == 0;
            coeff_addr = 4'($urandom % 12);
            coeff_data = 16'($urandom);
            commit     = ($urandom % 150) == 0;
            if (($urandom % 800) == 0) en = !en;
            tick();
        end
        in_vld = 0; clr = 0; coeff_wr = 0; commit = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
